// File: rtl/rpn_pkg.sv
// ---------------------------------------------------------------------------
// rpn_pkg -- shared definitions for the RPN calculator key front end.
//
// Holds the 4-bit command code enum (also used by the downstream calculator),
// the key front-end FSM state type and two small decode helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package rpn_pkg;

  typedef enum logic [3:0] {
    OP_PUSH = 4'd0,
    OP_POP  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_MUL  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_LT   = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_NOR  = 4'd10,
    OP_XOR  = 4'd11,
    OP_SWAP = 4'd12
  } rpn_op_e;

  // Codes 13..15 are reserved and are dropped by the front end.
  localparam logic [3:0] OP_FIRST_RESERVED = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_VALID   = 2'd1,
    ST_RELEASE = 2'd2
  } front_state_e;

  // Slot numbering runs opposite to the key bit index: KEY3 is slot 0.
  function automatic logic [1:0] key_slot(input logic [3:0] fall);
    logic [1:0] slot;
    if (fall[3])      slot = 2'd0;
    else if (fall[2]) slot = 2'd1;
    else if (fall[1]) slot = 2'd2;
    else              slot = 2'd3;
    return slot;
  endfunction

  function automatic logic is_reserved(input logic [3:0] code);
    return (code >= OP_FIRST_RESERVED);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce -- one push button: 2-flop synchronizer plus run-length
// debouncer.
//
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   key_raw   raw active-low button level, asynchronous to clk
//   sample    synchronized (not yet debounced) level
//   level     accepted (debounced) level, reset value 1
//   fall      one-cycle pulse on the cycle level becomes 0
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic sample,
  output logic level,
  output logic fall
);

  localparam logic [15:0] RUN_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        sync1_reg;
  logic        sync2_reg;
  logic [15:0] run_reg;
  logic        level_reg;
  logic        fall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      run_reg   <= '0;
      level_reg <= 1'b1;
      fall_reg  <= 1'b0;
    end else begin
      sync1_reg <= key_raw;
      sync2_reg <= sync1_reg;
      fall_reg  <= 1'b0;
      // run_reg counts consecutive samples that disagree with the accepted
      // level; the DEBOUNCE_CYCLES-th such sample flips the level.
      if (sync2_reg == level_reg) begin
        run_reg <= '0;
      end else if (run_reg == RUN_LAST) begin
        run_reg   <= '0;
        level_reg <= sync2_reg;
        fall_reg  <= ~sync2_reg;
      end else begin
        run_reg <= run_reg + 16'd1;
      end
    end
  end

  assign sample = sync2_reg;
  assign level  = level_reg;
  assign fall   = fall_reg;

endmodule

// File: rtl/key_cmd_front.sv
// ---------------------------------------------------------------------------
// key_cmd_front -- turns four debounced push buttons plus mode/operand
// switches into single calculator commands with a valid/ready handshake.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   key[3:0]     raw KEY3..KEY0, active-low, asynchronous
//   mode[1:0]    operation bank {SW17,SW16}
//   val[15:0]    operand SW15..SW0
//   cmd_ready    downstream can accept a command this cycle
//   cmd_valid    command available
//   cmd_op       command code {mode, slot}
//   cmd_val      operand captured with the command
//   cmd_illegal  one-cycle pulse when a reserved code is dropped
//   cmd_count    accepted-command counter (wraps), drives LEDG
// ---------------------------------------------------------------------------
module key_cmd_front
  import rpn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key,
  input  logic [1:0]  mode,
  input  logic [15:0] val,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [3:0]  cmd_op,
  output logic [15:0] cmd_val,
  output logic        cmd_illegal,
  output logic [7:0]  cmd_count
);

  logic [3:0] sample;
  logic [3:0] level;
  logic [3:0] fall;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .key_raw (key[gi]),
        .sample  (sample[gi]),
        .level   (level[gi]),
        .fall    (fall[gi])
      );
    end
  endgenerate

  // Reset forces every synchronizer to "released", so a button held through
  // reset would otherwise look like a fresh press. Press events stay
  // disabled until all synchronized samples have read released for
  // DEBOUNCE_CYCLES+2 consecutive cycles, which outlasts the synchronizer
  // pipeline and forces a full release of any key held across reset.
  localparam logic [16:0] ARM_LAST = 17'(DEBOUNCE_CYCLES + 1);

  logic [16:0] arm_cnt_reg;
  logic        armed_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      arm_cnt_reg <= '0;
      armed_reg   <= 1'b0;
    end else if (!armed_reg) begin
      if (&sample) begin
        if (arm_cnt_reg == ARM_LAST) armed_reg   <= 1'b1;
        else                         arm_cnt_reg <= arm_cnt_reg + 17'd1;
      end else begin
        arm_cnt_reg <= '0;
      end
    end
  end

  // A press event is exactly one key newly accepted low while the other
  // three are still accepted high.
  logic       press_event;
  logic [3:0] press_code;

  assign press_event = armed_reg && $onehot(fall) && ((level | fall) == 4'hF);
  assign press_code  = {mode, key_slot(fall)};

  front_state_e state_reg, state_next;
  logic [3:0]   cmd_op_reg, cmd_op_next;
  logic [15:0]  cmd_val_reg, cmd_val_next;
  logic         cmd_illegal_reg, cmd_illegal_next;
  logic [7:0]   cmd_count_reg, cmd_count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      cmd_op_reg      <= '0;
      cmd_val_reg     <= '0;
      cmd_illegal_reg <= 1'b0;
      cmd_count_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      cmd_op_reg      <= cmd_op_next;
      cmd_val_reg     <= cmd_val_next;
      cmd_illegal_reg <= cmd_illegal_next;
      cmd_count_reg   <= cmd_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cmd_op_next      = cmd_op_reg;
    cmd_val_next     = cmd_val_reg;
    cmd_illegal_next = 1'b0;
    cmd_count_next   = cmd_count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (press_event) begin
          if (is_reserved(press_code)) begin
            state_next       = ST_RELEASE;
            cmd_illegal_next = 1'b1;
          end else begin
            state_next   = ST_VALID;
            cmd_op_next  = press_code;
            cmd_val_next = val;
          end
        end
      end
      ST_VALID: begin
        if (cmd_ready) begin
          state_next     = ST_RELEASE;
          cmd_count_next = cmd_count_reg + 8'd1;
        end
      end
      ST_RELEASE: begin
        if (&level) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign cmd_valid   = (state_reg == ST_VALID);
  assign cmd_op      = cmd_op_reg;
  assign cmd_val     = cmd_val_reg;
  assign cmd_illegal = cmd_illegal_reg;
  assign cmd_count   = cmd_count_reg;

endmodule

// File: tb/tb_key_cmd_front.sv
// ---------------------------------------------------------------------------
// tb_key_cmd_front -- self-checking bench for key_cmd_front
// (DEBOUNCE_CYCLES = 4). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, away from the edge.
// Expected values come from a transaction-level model: a press of key i with
// bank m yields code {m, 3-i}, appears D+2 edges after the key goes low,
// codes >= 13 are dropped with a pulse, and the count advances mod 256 per
// transfer.
// ---------------------------------------------------------------------------
module tb_key_cmd_front;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key;
  logic [1:0]  mode;
  logic [15:0] val;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_val;
  logic        cmd_illegal;
  logic [7:0]  cmd_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  key_cmd_front #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .mode        (mode),
    .val         (val),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_val     (cmd_val),
    .cmd_illegal (cmd_illegal),
    .cmd_count   (cmd_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle for n cycles; any command or illegal pulse counts as one failure.
  task automatic quiet(input int n, input string name);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (cmd_valid !== 1'b0 || cmd_illegal !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d cycles with valid/illegal high, required 0", name, bad);
    end
  endtask

  task automatic check_count(input string name);
    checks++;
    if (cmd_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL %s: cmd_count=%0d required %0d", name, cmd_count, exp_count);
    end
  endtask

  // One complete press/handshake/release transaction on key idx.
  task automatic do_press(input int idx, input logic [1:0] m, input logic [15:0] v,
                          input int stall);
    logic [3:0] code;
    bit         reserved;
    int         early;
    code     = {m, 2'(3 - idx)};
    reserved = (code >= 4'd13);
    mode      = m;
    val       = v;
    cmd_ready = (stall == 0);
    key[idx]  = 1'b0;
    early = 0;
    for (int k = 0; k < D + 2; k++) begin
      tick();
      if (cmd_valid !== 1'b0 || cmd_illegal !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL press_latency_early key%0d: %0d early cycles, required 0", idx, early);
    end
    tick();
    if (reserved) begin
      checks++;
      if (cmd_illegal !== 1'b1 || cmd_valid !== 1'b0) begin
        errors++;
        $display("FAIL illegal_pulse code=%0d: illegal=%b valid=%b required 1/0",
                 code, cmd_illegal, cmd_valid);
      end
      tick();
      checks++;
      if (cmd_illegal !== 1'b0 || cmd_valid !== 1'b0) begin
        errors++;
        $display("FAIL illegal_one_cycle code=%0d: illegal=%b valid=%b required 0/0",
                 code, cmd_illegal, cmd_valid);
      end
      check_count("illegal_no_count");
      $display("press key%0d mode=%0d code=%0d dropped (reserved)", idx, m, code);
    end else begin
      checks++;
      if (cmd_valid !== 1'b1 || cmd_op !== code || cmd_val !== v) begin
        errors++;
        $display("FAIL cmd_present key%0d: valid=%b op=%0d val=%h required 1 op=%0d val=%h",
                 idx, cmd_valid, cmd_op, cmd_val, code, v);
      end
      for (int k = 0; k < stall; k++) begin
        mode = 2'($urandom);
        val  = 16'($urandom);
        tick();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== code || cmd_val !== v) begin
          errors++;
          $display("FAIL cmd_hold stall%0d: valid=%b op=%0d val=%h required 1 op=%0d val=%h",
                   k, cmd_valid, cmd_op, cmd_val, code, v);
        end
      end
      cmd_ready = 1'b1;
      tick();
      exp_count = (exp_count + 1) % 256;
      checks++;
      if (cmd_valid !== 1'b0) begin
        errors++;
        $display("FAIL cmd_drop_after_xfer: valid=%b required 0", cmd_valid);
      end
      check_count("xfer_count");
      $display("press key%0d mode=%0d op=%0d val=%h stall=%0d count=%0d",
               idx, m, code, v, stall, exp_count);
    end
    key[idx]  = 1'b1;
    cmd_ready = 1'($urandom);
    quiet(2 * D + 4, "release_quiet");
    check_count("release_count");
  endtask

  task automatic do_glitch(input int idx, input int len);
    key[idx] = 1'b0;
    repeat (len) tick();
    key[idx] = 1'b1;
    quiet(2 * D + 4, "glitch_quiet");
    check_count("glitch_count");
    $display("glitch key%0d len=%0d", idx, len);
  endtask

  task automatic test_reset();
    rst = 1'b1; key = 4'hF; mode = 2'd0; val = 16'd0; cmd_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (cmd_valid !== 1'b0 || cmd_op !== 4'd0 || cmd_val !== 16'd0 ||
        cmd_illegal !== 1'b0 || cmd_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b op=%0d val=%h illegal=%b count=%0d required all 0",
               cmd_valid, cmd_op, cmd_val, cmd_illegal, cmd_count);
    end
    rst = 1'b0;
    exp_count = 0;
    quiet(12, "post_reset_quiet");
    $display("reset done");
  endtask

  task automatic test_basic();
    do_press(3, 2'b00, 16'h1234, 0);
  endtask

  task automatic test_glitch();
    do_glitch(1, D - 1);
    for (int i = 0; i < 4; i++) do_glitch($urandom_range(3, 0), $urandom_range(D - 1, 1));
  endtask

  task automatic test_illegal();
    do_press(0, 2'b11, 16'hBEEF, 0);
    do_press(1, 2'b11, 16'h0001, 0);
    do_press(2, 2'b11, 16'h0002, 1);
    do_press(3, 2'b11, 16'h5A5A, 0);
  endtask

  task automatic test_stall();
    do_press(2, 2'b10, 16'hCAFE, 10);
  endtask

  task automatic test_overlap();
    mode = 2'b00; val = 16'h0042; cmd_ready = 1'b0;
    key[2] = 1'b0;
    repeat (D + 3) tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== 4'd1 || cmd_val !== 16'h0042) begin
      errors++;
      $display("FAIL overlap_first: valid=%b op=%0d val=%h required 1 op=1 val=0042",
               cmd_valid, cmd_op, cmd_val);
    end
    cmd_ready = 1'b1;
    tick();
    exp_count = (exp_count + 1) % 256;
    check_count("overlap_first_count");
    key[0] = 1'b0;
    quiet(3 * D, "overlap_second_ignored");
    key = 4'hF;
    quiet(2 * D + 4, "overlap_release");
    check_count("overlap_count");
    $display("overlap key2 then key0 held: one command");
    do_press(0, 2'b00, 16'h0099, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(3, 0) == 0)
        do_glitch($urandom_range(3, 0), $urandom_range(D - 1, 1));
      else
        do_press($urandom_range(3, 0), 2'($urandom), 16'($urandom), $urandom_range(5, 0));
    end
  endtask

  task automatic test_reset_in_valid();
    mode = 2'b01; val = 16'h7777; cmd_ready = 1'b0;
    key[3] = 1'b0;
    repeat (D + 3) tick();
    checks++;
    if (cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup_valid: valid=%b required 1", cmd_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = 0;
    checks++;
    if (cmd_valid !== 1'b0 || cmd_count !== 8'd0 || cmd_op !== 4'd0 || cmd_val !== 16'd0) begin
      errors++;
      $display("FAIL rst_in_valid: valid=%b count=%0d op=%0d val=%h required 0/0/0/0",
               cmd_valid, cmd_count, cmd_op, cmd_val);
    end
    cmd_ready = 1'b1;
    quiet(5 * D, "held_after_reset");
    check_count("held_after_reset_count");
    key[3] = 1'b1;
    quiet(3 * D, "release_after_reset");
    $display("reset during VALID: command discarded");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) do_press(3, 2'b00, 16'(i), 0);
    checks++;
    if (cmd_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap_256: cmd_count=%0d required 0", cmd_count);
    end
    $display("256 pushes: count wrapped to %0d", cmd_count);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_illegal();
    test_stall();
    test_overlap();
    test_random();
    test_reset_in_valid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_cmd_front.md
KEY_CMD_FRONT -- requirements
Module: key_cmd_front

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive equal synchronized samples needed to accept a new key level (legal 2..65535).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 key  input  4  raw KEY3..KEY0; active-low (0 = pressed); asynchronous to clk.
REQ-005 mode  input  2  {SW17,SW16} operation bank.
REQ-006 val  input  16  SW15..SW0 operand.
REQ-007 cmd_ready  input  1  downstream calculator can accept a command this cycle.
REQ-008 cmd_valid  output  1  command available.
REQ-009 cmd_op  output  4  command code.
REQ-010 cmd_val  output  16  operand captured with the command.
REQ-011 cmd_illegal  output  1  one-cycle pulse when a reserved code is dropped.
REQ-012 cmd_count  output  8  accepted-command counter, drives LEDG.

Function
REQ-013 Each key bit passes through a 2-flop synchronizer, reset value 1.
REQ-014 Per key: accepted level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the current accepted level; any matching sample clears the run counter.
REQ-015 Press event: exactly one accepted level goes 1->0 while the other three accepted levels are 1; a 1->0 transition while another key is accepted-low is ignored.
REQ-016 Key slot: key[3]=0, key[2]=1, key[1]=2, key[0]=3; cmd_op = {mode, slot}, mode and val sampled on the press-event cycle.
REQ-017 Codes: 0 push, 1 pop, 2 add, 3 sub, 4 mul, 5 sll, 6 srl, 7 lt, 8 and, 9 or, 10 nor, 11 xor, 12 swap; 13-15 reserved.
REQ-018 FSM states IDLE, VALID, RELEASE.
REQ-019 IDLE: legal press event -> VALID, cmd_op/cmd_val registered; reserved press event -> RELEASE with cmd_illegal high for one cycle; otherwise stay.
REQ-020 VALID: cmd_valid=1; cmd_op and cmd_val held stable regardless of mode/val changes; cmd_ready=1 -> RELEASE, cmd_count+1.
REQ-021 Handshake: transfer occurs on a rising edge where cmd_valid and cmd_ready are both 1; cmd_valid deasserts the following cycle; cmd_ready has no effect outside VALID.
REQ-022 RELEASE: cmd_valid=0; stays until all four accepted levels are 1, then IDLE the next cycle.
REQ-023 Press events arising in VALID or RELEASE are discarded, never queued.
REQ-024 Latency: key held low from edge E0 onward -> cmd_valid=1 after edge E0+DEBOUNCE_CYCLES+2 (idle, no other key down).
REQ-025 cmd_count wraps 255 -> 0; reserved codes never increment it.
REQ-026 Glitches shorter than DEBOUNCE_CYCLES samples produce no press event and no release.

Reset
REQ-027 On rst: state IDLE, cmd_valid=0, cmd_op=0, cmd_val=0, cmd_illegal=0, cmd_count=0, synchronizers and accepted levels 4'b1111, run counters 0.
REQ-028 rst asserted in VALID discards the pending command with no transfer and no count; a key still held after rst release requires full release before another command.

Structure
REQ-029 Package rpn_pkg holds the 4-bit command enum (REQ-017) and the FSM state typedef; the downstream calculator imports the same enum.
REQ-030 One sub-module key_debounce (1-bit synchronizer plus run counter, parameter DEBOUNCE_CYCLES) instantiated four times; FSM, decode and counter live in key_cmd_front.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 mode=00, val=16'h1234, key[3] low held, cmd_ready=1 -> cmd_valid=1 at E0+6 for one cycle, cmd_op=0, cmd_val=16'h1234, cmd_count=1.
REQ-032 key[1] low for 3 cycles then high -> no cmd_valid, cmd_count unchanged.
REQ-033 mode=11, key[0] pressed -> cmd_illegal one-cycle pulse, cmd_valid=0, cmd_count unchanged; mode=11, key[3] -> cmd_op=12.
REQ-034 cmd_ready=0 for 10 cycles after press with mode=10, key[2], val changed mid-wait -> cmd_valid held, cmd_op=9, cmd_val unchanged, transfer on first cmd_ready=1.
REQ-035 key[2] held, key[0] pressed, then both released, key[0] pressed -> one command op=1, then one command op=3; no command from the overlapping press.
REQ-036 256 push commands from cmd_count=0 -> cmd_count=0; rst during VALID -> cmd_valid=0 next cycle, count 0.
